// File: rtl/uart_tx_buffer.sv
// Byte FIFO that feeds a uart_tx core one byte at a time.
// Handshakes with the core through tx_dv / tx_active / tx_done.
module uart_tx_buffer #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     tx_active,
   input  logic                     tx_done,
   input  logic                     clr_ovf,
   output logic                     tx_dv,
   output logic [7:0]               tx_byte,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_ACT,
      WAIT_DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;
   logic          push;
   logic          drop;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // The core is not reset with us, so never start while it is busy.
   assign pop  = (state == IDLE) && !empty && !tx_active;
   assign push = wr_en && (!full || pop);
   assign drop = wr_en && full && !pop;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (pop) state_nx = SEND;
         end
         SEND: begin
            state_nx = WAIT_ACT;
         end
         WAIT_ACT: begin
            if (tx_done)        state_nx = IDLE;
            else if (tx_active) state_nx = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done || !tx_active) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset && push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         tx_dv    <= 1'b0;
         tx_byte  <= 8'h00;
      end else begin
         tx_dv <= pop;
         if (pop) begin
            tx_byte <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         // A drop in the same cycle as a clear wins.
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of FIFO byte entries; DEPTH is a power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_en  input  1  one-cycle byte-write strobe, driven by Peripheral TX_EN.
REQ-005 SHALL have port wr_data  input  8  byte to enqueue, driven by Peripheral TX_DATA.
REQ-006 SHALL have port tx_active  input  1  from uart_tx o_Tx_Active.
REQ-007 SHALL have port tx_done  input  1  from uart_tx o_Tx_Done; a one-cycle pulse.
REQ-008 SHALL have port tx_dv  output  1  to uart_tx i_Tx_DV; a registered one-cycle start pulse.
REQ-009 SHALL have port tx_byte  output  8  to uart_tx i_Tx_Byte; registered.
REQ-010 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port full  output  1  high when count==DEPTH.
REQ-012 SHALL have port empty  output  1  high when count==0.
REQ-013 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-014 SHALL have port clr_ovf  input  1  clears overflow.

Function
REQ-015 SHALL store bytes in a circular FIFO with log2(DEPTH)-bit read and write pointers.
REQ-016 SHALL let both pointers wrap from DEPTH-1 to 0 without affecting count.
REQ-017 SHALL accept a write when wr_en=1 and either (full=0) or (a pop occurs in the same cycle).
REQ-018 SHALL, on an accepted write, store mem[wr_ptr]<=wr_data, increment wr_ptr and update count at the same edge.
REQ-019 SHALL drop a write with wr_en=1, full=1 and no same-cycle pop, leaving FIFO contents and pointers unchanged and setting overflow<=1.
REQ-020 SHALL leave count unchanged on a same-cycle push and pop, while both pointers advance.
REQ-021 SHALL, when overflow set and clr_ovf occur in the same cycle, give set priority (overflow stays 1).
REQ-022 SHALL implement a sender FSM with states IDLE, SEND, WAIT_ACT and WAIT_DONE.
REQ-023 SHALL, in IDLE with empty=0 and tx_active=0, go to SEND and at the same edge load tx_byte<=mem[rd_ptr], set tx_dv<=1 and pop (rd_ptr++, count--).
REQ-024 SHALL hold tx_dv=1 for exactly one cycle (the SEND state), then go to WAIT_ACT with tx_dv<=0.
REQ-025 SHALL, in WAIT_ACT, go to WAIT_DONE when tx_active=1.
REQ-026 SHALL, in WAIT_ACT, go to IDLE directly when tx_done=1.
REQ-027 SHALL, in WAIT_DONE, go to IDLE when tx_done=1 or tx_active=0.
REQ-028 SHALL hold tx_byte stable from SEND until the next SEND.
REQ-029 SHALL have a latency of 2 edges from an accepted write into an empty, idle buffer to tx_dv=1: the write edge, then the IDLE->SEND edge.
REQ-030 SHALL return to IDLE after a byte completes and, if the FIFO is non-empty, issue the next tx_dv on the following edge, i.e. back-to-back with one IDLE cycle.
REQ-031 SHALL never issue tx_dv while tx_active=1.

Reset
REQ-032 SHALL, when reset=1 at a clock edge, set pointers=0, count=0, empty=1, full=0, overflow=0, tx_dv=0, tx_byte=8'h00 and FSM=IDLE.
REQ-033 SHALL give reset priority over wr_en, clr_ovf and all FSM transitions.
REQ-034 SHALL discard any in-flight byte when reset occurs mid-transmission.
REQ-035 SHALL, after a mid-transmission reset, not drive a new tx_dv until tx_active is sampled 0, because uart_tx is not reset.
REQ-036 SHALL leave FIFO memory contents undefined after reset; contents are never observable while empty.

Verification
REQ-037 SHALL cover: reset, then write 8'hA5 in an idle state with tx_active=0 -> count=1 one edge later; tx_dv=1 with tx_byte=8'hA5 exactly one cycle later; count=0.
REQ-038 SHALL cover: write 8'h01..8'h08 on consecutive cycles while tx_active is held 1 -> full=1, count=8; a 9th write of 8'h09 is dropped and overflow=1; released bytes emerge in order 01..08.
REQ-039 SHALL cover: with the FIFO full, sender in IDLE and tx_active=0, assert wr_en=1 in the same cycle as the pop -> write accepted, count stays 8, overflow stays 0.
REQ-040 SHALL cover: overflow=1, then assert clr_ovf together with a dropped write -> overflow remains 1; then clr_ovf alone -> overflow=0.
REQ-041 SHALL cover: enqueue 3 bytes with a uart_tx model, reset asserted while in WAIT_DONE and tx_active=1 -> all outputs at reset values next edge; then write 8'h3C -> no tx_dv until tx_active=0, then tx_byte=8'h3C.
REQ-042 SHALL cover wrap-around: 20 bytes streamed through DEPTH=8 -> pointers wrap and the output byte sequence matches the input exactly.
